// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame debounce and 4-digit code history
// Columns strobe active-low; each frame of four column samples is classified and debounced.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [4:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [19:0] disps
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
    typedef enum logic {ARMED, HELD} state_t;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [1:0]    hits_q, hits_d;
    logic [4:0]    hit_code_q, hit_code_d;
    cls_t          prev_cls_q, prev_cls_d;
    logic [4:0]    prev_key_q, prev_key_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;

    state_t        state_q;
    logic [4:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [19:0]   disps_q;

    logic          last_div;
    logic          frame_end;
    logic [2:0]    samp_cnt;
    logic [1:0]    samp_row;
    logic [2:0]    hit_sum;
    logic [1:0]    frm_hits;
    logic [4:0]    frm_code;
    cls_t          frm_cls;
    logic [4:0]    frm_key;
    logic [CW-1:0] cnt_next;

    assign col       = ~(4'b1000 >> col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign disps     = disps_q;

    always_comb begin
        last_div  = (div_q == DIV_LAST);
        frame_end = last_div && (col_idx_q == 2'd3);

        // Descending scan so the lowest pressed row wins when reporting a single hit.
        samp_cnt = 3'd0;
        samp_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                samp_cnt = samp_cnt + 3'd1;
                samp_row = 2'(r);
            end
        end

        hit_sum  = {1'b0, hits_q} + samp_cnt;
        frm_hits = last_div ? ((hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0]) : hits_q;
        frm_code = (last_div && samp_cnt != 3'd0) ? {1'b0, col_idx_q, samp_row} : hit_code_q;

        case (frm_hits)
            2'd0:    frm_cls = CLS_NONE;
            2'd1:    frm_cls = CLS_SINGLE;
            default: frm_cls = CLS_MULTI;
        endcase
        // Code only distinguishes SINGLE results; NONE/MULTI compare on class alone.
        frm_key = (frm_cls == CLS_SINGLE) ? frm_code : 5'd0;

        if (frm_cls == prev_cls_q && frm_key == prev_key_q)
            cnt_next = (stable_cnt_q == DEB_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
        else
            cnt_next = CW'(1);

        div_d        = div_q;
        col_idx_d    = col_idx_q;
        hits_d       = hits_q;
        hit_code_d   = hit_code_q;
        prev_cls_d   = prev_cls_q;
        prev_key_d   = prev_key_q;
        stable_cnt_d = stable_cnt_q;

        if (last_div) begin
            div_d      = '0;
            col_idx_d  = col_idx_q + 2'd1;
            hits_d     = frm_hits;
            hit_code_d = frm_code;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (frame_end) begin
            hits_d       = 2'd0;
            hit_code_d   = 5'd0;
            prev_cls_d   = frm_cls;
            prev_key_d   = frm_key;
            stable_cnt_d = cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            row_s1_q     <= 4'hF;
            row_s2_q     <= 4'hF;
            hits_q       <= 2'd0;
            hit_code_q   <= 5'd0;
            prev_cls_q   <= CLS_NONE;
            prev_key_q   <= 5'd0;
            stable_cnt_q <= '0;
        end else begin
            div_q        <= div_d;
            col_idx_q    <= col_idx_d;
            row_s1_q     <= row;
            row_s2_q     <= row_s1_q;
            hits_q       <= hits_d;
            hit_code_q   <= hit_code_d;
            prev_cls_q   <= prev_cls_d;
            prev_key_q   <= prev_key_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARMED;
            key_code_q  <= 5'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            disps_q     <= 20'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    ARMED: begin
                        if (frm_cls == CLS_SINGLE && cnt_next == DEB_MAX) begin
                            key_code_q  <= frm_key;
                            disps_q     <= {disps_q[14:0], frm_key};
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            state_q     <= HELD;
                        end
                    end
                    HELD: begin
                        if (frm_cls == CLS_NONE && cnt_next == DEB_MAX) begin
                            key_held_q <= 1'b0;
                            state_q    <= ARMED;
                        end
                    end
                    default: state_q <= ARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3)
// Key matrix is held per 16-clock frame; a frame-level model predicts reports.
module tb_keypad_scan;

    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SDIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [19:0] disps;

    logic [15:0] keys = 16'h0;

    keypad_scan #(.SCAN_DIV(SDIV), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .disps(disps)
    );

    always #5 clk = ~clk;

    // Key index c*4+r connects column c to row r; column c drives col bit 3-c low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col[3 - c])
                for (int r = 0; r < 4; r++)
                    if (keys[c * 4 + r]) row[r] = 1'b0;
    end

    int n_cmp = 0;
    int n_err = 0;
    int phase = 0;
    logic [3:0] col_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    int          hist[$];
    bit          m_armed = 1'b1;
    logic [4:0]  m_code  = 5'd0;
    bit          m_held  = 1'b0;
    logic [19:0] m_disps = 20'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [15:0] k);
        if ($countones(k) == 0) return -1;
        if ($countones(k) > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    // Report when the last DEB frame results are one identical single key and no key is held.
    task automatic model_frame(input logic [15:0] k, output bit pulse);
        int res;
        bit stable;
        res = classify(k);
        pulse = 1'b0;
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        stable = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
        if (m_armed && res >= 0 && stable) begin
            pulse   = 1'b1;
            m_code  = res[4:0];
            m_disps = {m_disps[14:0], m_code};
            m_held  = 1'b1;
            m_armed = 1'b0;
        end else if (!m_armed && res == -1 && stable) begin
            m_held  = 1'b0;
            m_armed = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [15:0] k, output int pulses);
        bit mp;
        keys = k;
        pulses = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % FRAME;
            check("col_strobe", {28'd0, col}, {28'd0, col_tab[phase / SDIV]});
            if (key_valid) pulses++;
        end
        model_frame(k, mp);
        check("pulse_count", pulses, mp ? 1 : 0);
        check("key_code", {27'd0, key_code}, {27'd0, m_code});
        check("key_held", {31'd0, key_held}, {31'd0, m_held});
        check("disps", {12'd0, disps}, {12'd0, m_disps});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_col", {28'd0, col}, 32'h7);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_held", {31'd0, key_held}, 32'd0);
        check("rst_key_code", {27'd0, key_code}, 32'd0);
        check("rst_disps", {12'd0, disps}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        hist.delete();
        m_armed = 1'b1;
        m_code  = 5'd0;
        m_held  = 1'b0;
        m_disps = 20'd0;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_pulses;
        logic [4:0]  exp_code;
        bit          exp_held;
        logic [19:0] exp_disps;
    } vec_t;

    vec_t tab [15];

    initial begin
        int p, tot, kind, len;
        logic [15:0] k;
        logic [15:0] bounce [8];

        tab[0]  = '{16'h0000, 2, 0, 5'h00, 1'b0, 20'h00000};
        tab[1]  = '{16'h0200, 6, 1, 5'h09, 1'b1, 20'h00009};
        tab[2]  = '{16'h0000, 3, 0, 5'h09, 1'b0, 20'h00009};
        tab[3]  = '{16'h4001, 6, 0, 5'h09, 1'b0, 20'h00009};
        tab[4]  = '{16'h0000, 3, 0, 5'h09, 1'b0, 20'h00009};
        tab[5]  = '{16'h0002, 4, 1, 5'h01, 1'b1, 20'h00121};
        tab[6]  = '{16'h0000, 3, 0, 5'h01, 1'b0, 20'h00121};
        tab[7]  = '{16'h0004, 4, 1, 5'h02, 1'b1, 20'h02422};
        tab[8]  = '{16'h0000, 3, 0, 5'h02, 1'b0, 20'h02422};
        tab[9]  = '{16'h0008, 4, 1, 5'h03, 1'b1, 20'h48443};
        tab[10] = '{16'h0000, 3, 0, 5'h03, 1'b0, 20'h48443};
        tab[11] = '{16'h0010, 4, 1, 5'h04, 1'b1, 20'h08864};
        tab[12] = '{16'h0000, 3, 0, 5'h04, 1'b0, 20'h08864};
        tab[13] = '{16'h0020, 4, 1, 5'h05, 1'b1, 20'h10C85};
        tab[14] = '{16'h0000, 3, 0, 5'h05, 1'b0, 20'h10C85};

        do_reset();

        for (int t = 0; t < 15; t++) begin
            tot = 0;
            for (int f = 0; f < tab[t].frames; f++) begin
                run_frame(tab[t].keys, p);
                tot += p;
            end
            check($sformatf("vec%0d_pulses", t), tot, tab[t].exp_pulses);
            check($sformatf("vec%0d_code", t), {27'd0, key_code}, {27'd0, tab[t].exp_code});
            check($sformatf("vec%0d_held", t), {31'd0, key_held}, {31'd0, tab[t].exp_held});
            check($sformatf("vec%0d_disps", t), {12'd0, disps}, {12'd0, tab[t].exp_disps});
        end

        // Bouncing press: only the third frame of the settled run reports.
        bounce = '{16'h0400, 16'h0, 16'h0400, 16'h0, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
        for (int f = 0; f < 8; f++) begin
            run_frame(bounce[f], p);
            check($sformatf("bounce_frame%0d", f), p, (f == 6) ? 1 : 0);
        end
        check("bounce_code", {27'd0, key_code}, 32'h0A);
        for (int f = 0; f < 3; f++) run_frame(16'h0, p);

        // Reset while a key is down, then keep holding it.
        for (int f = 0; f < 4; f++) run_frame(16'h0200, p);
        repeat (7) @(posedge clk);
        do_reset();
        for (int f = 0; f < 5; f++) begin
            run_frame(16'h0200, p);
            check($sformatf("rehold_frame%0d", f), p, (f == 2) ? 1 : 0);
        end
        check("rehold_code", {27'd0, key_code}, 32'h09);
        check("rehold_disps", {12'd0, disps}, 32'h00009);
        check("rehold_held", {31'd0, key_held}, 32'd1);
        for (int f = 0; f < 3; f++) run_frame(16'h0, p);

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 19);
            if (kind < 9)
                k = 16'h0;
            else if (kind < 16)
                k = 16'h1 << $urandom_range(0, 15);
            else
                k = (16'h1 << $urandom_range(0, 7)) | (16'h100 << $urandom_range(0, 7));
            len = $urandom_range(1, 5);
            for (int f = 0; f < len; f++) run_frame(k, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
